// File: rtl/parking_pkg.sv
// parking_pkg: shared mode encoding and gate-response bundle for the parking allocation controller
package parking_pkg;
  localparam int CNT_W_DEF = 10;
  typedef enum logic [1:0] {NIGHT = 2'd0, DAY = 2'd1, SHIFT = 2'd2, RELEASED = 2'd3} mode_e;
  typedef struct packed {
    logic grant;
    logic deny;
    logic exit_err;
  } rsp_t;
endpackage

// File: rtl/parking_alloc_ctrl_if.sv
// parking_alloc_ctrl_if: gate sensor inputs and occupancy/display outputs of the controller
interface parking_alloc_ctrl_if #(parameter int CNT_W = parking_pkg::CNT_W_DEF);
  logic [4:0]       hour;
  logic             entry_req, entry_res, exit_req, exit_res;
  logic             entry_grant, entry_deny, exit_err, shift_skip;
  logic [1:0]       mode;
  logic [CNT_W-1:0] res_parked, pub_parked, res_cap, pub_cap, res_free, pub_free;
  logic             res_avail, pub_avail;
  modport master (
    output hour, entry_req, entry_res, exit_req, exit_res,
    input  entry_grant, entry_deny, exit_err, shift_skip, mode,
    input  res_parked, pub_parked, res_cap, pub_cap, res_free, pub_free, res_avail, pub_avail
  );
  modport slave (
    input  hour, entry_req, entry_res, exit_req, exit_res,
    output entry_grant, entry_deny, exit_err, shift_skip, mode,
    output res_parked, pub_parked, res_cap, pub_cap, res_free, pub_free, res_avail, pub_avail
  );
endinterface

// File: rtl/parking_pool.sv
// parking_pool: occupancy, registered free count and gate responses for one parking class
module parking_pool import parking_pkg::*; #(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int RST_FREE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             entry,
  input  logic             exit,
  input  logic [CNT_W-1:0] cap_n,
  output logic [CNT_W-1:0] parked,
  output logic [CNT_W-1:0] free,
  output logic [CNT_W-1:0] n_parked,
  output logic             avail,
  output rsp_t             rsp
);
  logic grant, ex_ok;
  // free tracks cap - parked of the same edge, so back-to-back entries can never overfill
  assign grant    = entry && free != '0;
  assign ex_ok    = exit && parked != '0;
  assign n_parked = parked + CNT_W'(grant) - CNT_W'(ex_ok);
  assign avail    = free != '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      parked <= '0;
      free   <= CNT_W'(RST_FREE);
      rsp    <= '0;
    end else begin
      parked <= n_parked;
      free   <= cap_n - n_parked;
      rsp    <= '{grant: grant, deny: entry && !grant, exit_err: exit && !ex_ok};
    end
endmodule

// File: rtl/parking_alloc_ctrl.sv
// parking_alloc_ctrl: two-class lot allocator with hour-driven capacity moves between reserved and public pools
module parking_alloc_ctrl import parking_pkg::*; #(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int TOTAL_CAP    = 700,
  parameter int RES_CAP_DAY  = 500,
  parameter int RES_STEP     = 50,
  parameter int RES_FLOOR    = 200,
  parameter int DAY_HOUR     = 8,
  parameter int SHIFT_FIRST  = 13,
  parameter int SHIFT_LAST   = 15,
  parameter int RELEASE_HOUR = 16
) (
  input logic clock,
  input logic reset,
  parking_alloc_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] TOT     = CNT_W'(TOTAL_CAP);
  localparam logic [CNT_W-1:0] DAY_CAP = CNT_W'(RES_CAP_DAY);
  localparam logic [CNT_W-1:0] STEP    = CNT_W'(RES_STEP);
  localparam logic [CNT_W-1:0] FLOOR   = CNT_W'(RES_FLOOR);
  localparam logic [4:0]       H_DAY   = 5'(DAY_HOUR);
  localparam logic [4:0]       H_S1    = 5'(SHIFT_FIRST);
  localparam logic [4:0]       H_SL    = 5'(SHIFT_LAST);
  localparam logic [4:0]       H_REL   = 5'(RELEASE_HOUR);
  function automatic logic [CNT_W-1:0] umin(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return a < b ? a : b;
  endfunction
  function automatic logic [CNT_W-1:0] umax(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return a > b ? a : b;
  endfunction
  logic [4:0]       hour_q;
  logic [CNT_W-1:0] res_cap_q, res_cap_n, pub_cap_n, nr, np;
  logic [CNT_W:0]   cand;
  logic             hr_ev, in_shift, shift_ok, skip_q, skip_n;
  mode_e            state, state_n;
  rsp_t             res_rsp, pub_rsp;
  assign hr_ev    = bus.hour != hour_q;
  assign in_shift = bus.hour >= H_S1 && bus.hour <= H_SL;
  // extra top bit catches a step larger than the current reserved capacity
  assign cand     = {1'b0, res_cap_q} - {1'b0, STEP};
  assign shift_ok = !cand[CNT_W] && cand[CNT_W-1:0] >= nr && cand[CNT_W-1:0] >= FLOOR;
  always_comb begin
    res_cap_n = !hr_ev               ? res_cap_q :
                bus.hour == H_DAY    ? umin(DAY_CAP, TOT - np) :
                in_shift             ? (shift_ok ? cand[CNT_W-1:0] : res_cap_q) :
                bus.hour == H_REL    ? umin(umax(nr, FLOOR), TOT - np) : res_cap_q;
    skip_n    = hr_ev && bus.hour != H_DAY && in_shift && !shift_ok;
  end
  assign pub_cap_n = TOT - res_cap_n;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= NIGHT;
    else       state <= state_n;
  always_comb
    state_n = !hr_ev            ? state :
              bus.hour == H_DAY ? DAY :
              in_shift          ? SHIFT :
              bus.hour == H_REL ? RELEASED :
              bus.hour == 5'd0  ? NIGHT : state;
  always_comb bus.mode = state;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      hour_q    <= 5'd31;
      res_cap_q <= DAY_CAP;
      skip_q    <= 1'b0;
    end else begin
      hour_q    <= bus.hour;
      res_cap_q <= res_cap_n;
      skip_q    <= skip_n;
    end
  parking_pool #(.CNT_W(CNT_W), .RST_FREE(RES_CAP_DAY)) u_res (
    .clock    (clock),
    .reset    (reset),
    .entry    (bus.entry_req && bus.entry_res),
    .exit     (bus.exit_req && bus.exit_res),
    .cap_n    (res_cap_n),
    .parked   (bus.res_parked),
    .free     (bus.res_free),
    .n_parked (nr),
    .avail    (bus.res_avail),
    .rsp      (res_rsp)
  );
  parking_pool #(.CNT_W(CNT_W), .RST_FREE(TOTAL_CAP - RES_CAP_DAY)) u_pub (
    .clock    (clock),
    .reset    (reset),
    .entry    (bus.entry_req && !bus.entry_res),
    .exit     (bus.exit_req && !bus.exit_res),
    .cap_n    (pub_cap_n),
    .parked   (bus.pub_parked),
    .free     (bus.pub_free),
    .n_parked (np),
    .avail    (bus.pub_avail),
    .rsp      (pub_rsp)
  );
  assign bus.entry_grant = res_rsp.grant | pub_rsp.grant;
  assign bus.entry_deny  = res_rsp.deny | pub_rsp.deny;
  assign bus.exit_err    = res_rsp.exit_err | pub_rsp.exit_err;
  assign bus.shift_skip  = skip_q;
  assign bus.res_cap     = res_cap_q;
  assign bus.pub_cap     = TOT - res_cap_q;
endmodule

// File: tb/tb_parking_alloc_ctrl.sv
// tb_parking_alloc_ctrl: directed vector table plus multi-cycle sequences for the parking allocator
module tb_parking_alloc_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  parking_alloc_ctrl_if #(.CNT_W(10)) bus();
  parking_alloc_ctrl dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  typedef struct {
    int h, er, eres, xr, xres;
    int g, d, e, s;
    int rp, pp, rcap, m;
  } vec_t;
  vec_t tv[19];
  int checks = 0;
  int errors = 0;
  int sk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int h, input int er, input int eres, input int xr, input int xres);
    bus.hour      = 5'(h);
    bus.entry_req = er != 0;
    bus.entry_res = eres != 0;
    bus.exit_req  = xr != 0;
    bus.exit_res  = xres != 0;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic fill(input int n, input int res, input int h);
    int g = 0;
    for (int i = 0; i < n; i++) begin
      drive(h, 1, res, 0, 0);
      g += int'(bus.entry_grant);
    end
    chk($sformatf("fill_grants_%0d", n), g, n);
  endtask

  task automatic hold(input int h, input int n, output int skips);
    skips = 0;
    for (int i = 0; i < n; i++) begin
      drive(h, 0, 0, 0, 0);
      skips += int'(bus.shift_skip);
    end
  endtask

  task automatic chk_state(input string tag, input int rp, input int pp, input int rcap, input int m);
    chk({tag, "_res_parked"}, int'(bus.res_parked), rp);
    chk({tag, "_pub_parked"}, int'(bus.pub_parked), pp);
    chk({tag, "_res_cap"},    int'(bus.res_cap), rcap);
    chk({tag, "_pub_cap"},    int'(bus.pub_cap), 700 - rcap);
    chk({tag, "_res_free"},   int'(bus.res_free), rcap - rp);
    chk({tag, "_pub_free"},   int'(bus.pub_free), 700 - rcap - pp);
    chk({tag, "_mode"},       int'(bus.mode), m);
  endtask

  task automatic chk_pulses(input string tag, input int g, input int d, input int e, input int s);
    chk({tag, "_grant"}, int'(bus.entry_grant), g);
    chk({tag, "_deny"},  int'(bus.entry_deny), d);
    chk({tag, "_err"},   int'(bus.exit_err), e);
    chk({tag, "_skip"},  int'(bus.shift_skip), s);
  endtask

  initial begin
    tv[0]  = '{8, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 500, 1};
    tv[1]  = '{8, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 500, 1};
    tv[2]  = '{8, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 500, 1};
    tv[3]  = '{8, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 500, 1};
    tv[4]  = '{8, 1, 1, 1, 1, 1, 0, 0, 0, 1, 0, 500, 1};
    tv[5]  = '{8, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 500, 1};
    tv[6]  = '{8, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 500, 1};
    tv[7]  = '{8, 1, 0, 1, 1, 1, 0, 1, 0, 0, 1, 500, 1};
    tv[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 500, 0};
    tv[9]  = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 500, 0};
    tv[10] = '{16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 200, 3};
    tv[11] = '{16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 200, 3};
    tv[12] = '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 500, 1};
    tv[13] = '{13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 450, 2};
    tv[14] = '{13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 450, 2};
    tv[15] = '{14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 400, 2};
    tv[16] = '{10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 400, 2};
    tv[17] = '{15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 350, 2};
    tv[18] = '{20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 350, 2};
    bus.hour = 5'd0;
    bus.entry_req = 1'b0;
    bus.entry_res = 1'b0;
    bus.exit_req = 1'b0;
    bus.exit_res = 1'b0;

    do_reset();
    chk_state("reset", 0, 0, 500, 0);
    chk_pulses("reset", 0, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      drive(tv[i].h, tv[i].er, tv[i].eres, tv[i].xr, tv[i].xres);
      chk_pulses($sformatf("vec%0d", i), tv[i].g, tv[i].d, tv[i].e, tv[i].s);
      chk_state($sformatf("vec%0d", i), tv[i].rp, tv[i].pp, tv[i].rcap, tv[i].m);
    end

    do_reset();
    fill(500, 1, 8);
    drive(8, 1, 1, 0, 0);
    chk_pulses("full_entry", 0, 1, 0, 0);
    chk("full_res_parked", int'(bus.res_parked), 500);
    chk("full_res_avail", int'(bus.res_avail), 0);
    drive(8, 1, 1, 1, 1);
    chk_pulses("full_entry_exit", 0, 1, 0, 0);
    chk("full_entry_exit_parked", int'(bus.res_parked), 499);
    chk("full_entry_exit_free", int'(bus.res_free), 1);
    drive(8, 1, 1, 0, 0);
    chk_pulses("refill", 1, 0, 0, 0);
    chk("refill_parked", int'(bus.res_parked), 500);
    drive(8, 0, 0, 1, 1);
    chk("one_exit_free", int'(bus.res_free), 1);
    chk("one_exit_avail", int'(bus.res_avail), 1);
    drive(8, 1, 1, 0, 0);
    chk_pulses("after_exit_entry", 1, 0, 0, 0);

    do_reset();
    fill(300, 1, 8);
    hold(8, 20, sk);
    hold(13, 20, sk);
    chk_state("shift13", 300, 0, 450, 2);
    chk("shift13_skips", sk, 0);
    hold(14, 20, sk);
    chk_state("shift14", 300, 0, 400, 2);
    hold(15, 20, sk);
    chk_state("shift15", 300, 0, 350, 2);

    do_reset();
    fill(460, 1, 8);
    drive(13, 0, 0, 0, 0);
    chk_pulses("skip", 0, 0, 0, 1);
    chk_state("skip", 460, 0, 500, 2);
    hold(13, 19, sk);
    chk("skip_once", sk, 0);

    do_reset();
    fill(120, 1, 8);
    drive(16, 0, 0, 0, 0);
    chk_state("release", 120, 0, 200, 3);
    fill(300, 0, 16);
    drive(8, 0, 0, 0, 0);
    chk_state("day_clamp", 120, 300, 400, 1);

    do_reset();
    fill(10, 1, 8);
    drive(8, 1, 1, 1, 1);
    chk_pulses("same_class_io", 1, 0, 0, 0);
    chk("same_class_io_parked", int'(bus.res_parked), 10);
    drive(8, 0, 0, 1, 0);
    chk_pulses("pub_exit_empty", 0, 0, 1, 0);
    chk("pub_exit_empty_parked", int'(bus.pub_parked), 0);

    #1 reset = 1'b1;
    #2;
    chk_state("mid_reset", 0, 0, 500, 0);
    chk_pulses("mid_reset", 0, 0, 0, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
